// File: rtl/operand_fetch_unit_pkg.sv
// rtl/operand_fetch_unit_pkg.sv - shared widths, types and register decode helpers
package operand_fetch_unit_pkg;

    function automatic int CeilLog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

    localparam int WORD_LENGTH = 32;
    localparam int NBITS       = CeilLog2(WORD_LENGTH);

    typedef logic [WORD_LENGTH-1:0] word_t;
    typedef logic [NBITS-1:0]       reg_idx_t;

    // Held operand bundle presented to the execute stage.
    typedef struct packed {
        word_t    a;
        word_t    b;
        reg_idx_t rd;
        logic     wen;
    } operand_t;

    // Register-number to one-hot decode; also used by the register file write demux.
    function automatic word_t onehot(input reg_idx_t idx);
        word_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/operand_fetch_unit_if.sv
// rtl/operand_fetch_unit_if.sv - issue, register-file, writeback and execute signals
// slave : the fetch unit (consumes requests, drives read addresses and operands)
// master: the surrounding pipeline / register file / execute stage
interface operand_fetch_unit_if;
    import operand_fetch_unit_pkg::*;

    logic     req_valid;
    logic     req_ready;
    reg_idx_t req_rs1;
    reg_idx_t req_rs2;
    reg_idx_t req_rd;
    logic     req_wen;

    reg_idx_t rf_read_reg1;
    reg_idx_t rf_read_reg2;
    word_t    rf_read_data1;
    word_t    rf_read_data2;

    logic     wb_valid;
    reg_idx_t wb_reg;
    word_t    wb_data;

    logic     flush;

    logic     op_valid;
    logic     op_ready;
    word_t    op_a;
    word_t    op_b;
    reg_idx_t op_rd;
    logic     op_wen;

    logic     pending;

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_rd, req_wen,
        input  rf_read_data1, rf_read_data2,
        input  wb_valid, wb_reg, wb_data,
        input  flush, op_ready,
        output req_ready, rf_read_reg1, rf_read_reg2,
        output op_valid, op_a, op_b, op_rd, op_wen, pending
    );

    modport master (
        output req_valid, req_rs1, req_rs2, req_rd, req_wen,
        output rf_read_data1, rf_read_data2,
        output wb_valid, wb_reg, wb_data,
        output flush, op_ready,
        input  req_ready, rf_read_reg1, rf_read_reg2,
        input  op_valid, op_a, op_b, op_rd, op_wen, pending
    );

endinterface

// File: rtl/operand_fetch_unit_scoreboard.sv
// rtl/operand_fetch_unit_scoreboard.sv - pending-write scoreboard with hazard lookups
// Ports: set (issue), clr (writeback), flush_clr (discarded instruction),
//        lookup1/lookup2/waw hit outputs against the writeback-adjusted bits, pending.
module reg_scoreboard
    import operand_fetch_unit_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     clr_en,
    input  reg_idx_t clr_idx,
    input  logic     flush_clr_en,
    input  reg_idx_t flush_clr_idx,
    input  reg_idx_t lookup1_idx,
    input  reg_idx_t lookup2_idx,
    input  reg_idx_t waw_idx,
    output logic     lookup1_hit,
    output logic     lookup2_hit,
    output logic     waw_hit,
    output logic     pending
);

    word_t sb_q;
    word_t sb_d;
    word_t eff;

    // A register being written back this cycle is no longer a hazard, which is
    // what lets a dependent instruction issue in the writeback cycle via bypass.
    always_comb begin
        eff  = sb_q & ~(clr_en ? onehot(clr_idx) : '0);
        sb_d = eff | (set_en ? onehot(set_idx) : '0);
        if (flush_clr_en) begin
            sb_d = sb_d & ~onehot(flush_clr_idx);
        end
    end

    assign lookup1_hit = eff[lookup1_idx];
    assign lookup2_hit = eff[lookup2_idx];
    assign waw_hit     = eff[waw_idx];
    assign pending     = |sb_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

endmodule

// File: rtl/operand_fetch_unit.sv
// rtl/operand_fetch_unit.sv - issue-side operand fetch with bypass and hazard stall
// Ports: clk, reset (async active-low), bus (operand_fetch_unit_if.slave).
module operand_fetch_unit
    import operand_fetch_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    operand_fetch_unit_if.slave  bus
);

    logic     hit1;
    logic     hit2;
    logic     hit_waw;
    logic     hazard;
    logic     accept;
    logic     flush_clr;
    logic     op_valid_q;
    logic     op_valid_d;
    operand_t op_q;
    operand_t op_d;

    assign bus.rf_read_reg1 = bus.req_rs1;
    assign bus.rf_read_reg2 = bus.req_rs2;

    assign hazard        = hit1 | hit2 | (bus.req_wen & hit_waw);
    assign bus.req_ready = reset & ~bus.flush & ~hazard & (~op_valid_q | bus.op_ready);
    assign accept        = bus.req_valid & bus.req_ready;

    // A flushed instruction never writes back, so its destination must be released.
    assign flush_clr = bus.flush & op_valid_q & op_q.wen;

    always_comb begin
        op_d       = op_q;
        op_valid_d = op_valid_q;
        if (bus.flush) begin
            op_valid_d = 1'b0;
        end else if (accept) begin
            op_valid_d = 1'b1;
            // The register file write lands at the end of this cycle, so the
            // read port still shows the old value; forward the writeback data.
            op_d.a   = (bus.wb_valid && bus.wb_reg == bus.req_rs1) ? bus.wb_data : bus.rf_read_data1;
            op_d.b   = (bus.wb_valid && bus.wb_reg == bus.req_rs2) ? bus.wb_data : bus.rf_read_data2;
            op_d.rd  = bus.req_rd;
            op_d.wen = bus.req_wen;
        end else if (bus.op_ready) begin
            op_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_valid_q <= 1'b0;
            op_q       <= '0;
        end else begin
            op_valid_q <= op_valid_d;
            op_q       <= op_d;
        end
    end

    assign bus.op_valid = op_valid_q;
    assign bus.op_a     = op_q.a;
    assign bus.op_b     = op_q.b;
    assign bus.op_rd    = op_q.rd;
    assign bus.op_wen   = op_q.wen;

    reg_scoreboard u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .set_en        (accept & bus.req_wen),
        .set_idx       (bus.req_rd),
        .clr_en        (bus.wb_valid),
        .clr_idx       (bus.wb_reg),
        .flush_clr_en  (flush_clr),
        .flush_clr_idx (op_q.rd),
        .lookup1_idx   (bus.req_rs1),
        .lookup2_idx   (bus.req_rs2),
        .waw_idx       (bus.req_rd),
        .lookup1_hit   (hit1),
        .lookup2_hit   (hit2),
        .waw_hit       (hit_waw),
        .pending       (bus.pending)
    );

endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb/tb_operand_fetch_unit.sv - randomized scoreboard bench for operand_fetch_unit
module tb_operand_fetch_unit;
    import operand_fetch_unit_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rd;
        logic        wen;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    operand_fetch_unit_if bus();

    operand_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] rf_mem [32];
    assign bus.rf_read_data1 = rf_mem[bus.rf_read_reg1];
    assign bus.rf_read_data2 = rf_mem[bus.rf_read_reg2];

    exp_t exp_q[$];
    bit   busy_m [32];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit any_busy();
        for (int r = 0; r < 32; r++) if (busy_m[r]) return 1'b1;
        return 1'b0;
    endfunction

    // A register blocks issue if a write is outstanding and not landing right now.
    function automatic bit blocks(input int r);
        return busy_m[r] && !(bus.wb_valid && int'(bus.wb_reg) == r);
    endfunction

    task automatic model_step();
        bit   held;
        bit   hazard;
        bit   rdy;
        bit   acc;
        exp_t e;
        exp_t h;
        held = (exp_q.size() != 0);
        chk("op_valid", bus.op_valid, held);
        chk("pending", bus.pending, any_busy());
        chk("rf_read_reg1", bus.rf_read_reg1, bus.req_rs1);
        chk("rf_read_reg2", bus.rf_read_reg2, bus.req_rs2);
        hazard = blocks(bus.req_rs1) || blocks(bus.req_rs2) || (bus.req_wen && blocks(bus.req_rd));
        rdy    = !bus.flush && !hazard && (!held || bus.op_ready);
        chk("req_ready", bus.req_ready, rdy);
        acc = bus.req_valid && rdy;
        if (acc) begin
            e.a   = (bus.wb_valid && bus.wb_reg == bus.req_rs1) ? bus.wb_data : rf_mem[bus.req_rs1];
            e.b   = (bus.wb_valid && bus.wb_reg == bus.req_rs2) ? bus.wb_data : rf_mem[bus.req_rs2];
            e.rd  = 32'(bus.req_rd);
            e.wen = bus.req_wen;
            exp_q.push_back(e);
        end
        if (bus.wb_valid) busy_m[bus.wb_reg] = 1'b0;
        if (acc && bus.req_wen) busy_m[bus.req_rd] = 1'b1;
        if (bus.flush && held) begin
            h = exp_q.pop_front();
            if (h.wen) busy_m[h.rd[4:0]] = 1'b0;
        end
    endtask

    task automatic run_cycle(input bit rnd);
        int lim;
        int plist[$];
        @(negedge clk);
        if (rnd) begin
            lim = ($urandom_range(0, 3) != 0) ? 7 : 31;
            bus.req_valid = ($urandom_range(0, 9) < 7);
            bus.req_rs1   = reg_idx_t'($urandom_range(0, lim));
            bus.req_rs2   = reg_idx_t'($urandom_range(0, lim));
            bus.req_rd    = reg_idx_t'($urandom_range(0, lim));
            bus.req_wen   = ($urandom_range(0, 9) < 6);
            for (int r = 0; r < 32; r++) if (busy_m[r]) plist.push_back(r);
            bus.wb_data  = $urandom;
            bus.wb_reg   = reg_idx_t'($urandom_range(0, 31));
            bus.wb_valid = ($urandom_range(0, 9) == 0);
            if (plist.size() != 0 && $urandom_range(0, 9) < 4) begin
                bus.wb_valid = 1'b1;
                bus.wb_reg   = reg_idx_t'(plist[$urandom_range(0, plist.size() - 1)]);
            end
            bus.flush    = ($urandom_range(0, 19) == 0);
            bus.op_ready = bus.flush ? 1'b0 : ($urandom_range(0, 3) != 0);
        end else begin
            bus.req_valid = 1'b0;
            bus.wb_valid  = 1'b0;
            bus.flush     = 1'b0;
            bus.op_ready  = 1'b1;
        end
        #1;
        model_step();
        @(posedge clk);
        #1;
        if (bus.wb_valid) rf_mem[bus.wb_reg] = bus.wb_data;
    endtask

    // Monitor: compares the held operands with the oldest expected entry every
    // cycle they are presented, and retires it on the execute handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset && bus.op_valid && !bus.flush) begin
                if (exp_q.size() == 0) begin
                    chk("op_unexpected", bus.op_valid, 1'b0);
                end else begin
                    e = exp_q[0];
                    chk("op_a", bus.op_a, e.a);
                    chk("op_b", bus.op_b, e.b);
                    chk("op_rd", bus.op_rd, e.rd);
                    chk("op_wen", bus.op_wen, e.wen);
                    if (bus.op_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        for (int r = 0; r < 32; r++) begin
            rf_mem[r] = $urandom;
            busy_m[r] = 1'b0;
        end
        reset         = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_rs1   = 1;
        bus.req_rs2   = 2;
        bus.req_rd    = 3;
        bus.req_wen   = 1'b1;
        bus.wb_valid  = 1'b0;
        bus.wb_reg    = '0;
        bus.wb_data   = '0;
        bus.flush     = 1'b0;
        bus.op_ready  = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_req_ready", bus.req_ready, 1'b0);
            chk("rst_op_valid", bus.op_valid, 1'b0);
            chk("rst_op_a", bus.op_a, 32'h0);
            chk("rst_op_b", bus.op_b, 32'h0);
            chk("rst_op_rd", bus.op_rd, 32'h0);
            chk("rst_op_wen", bus.op_wen, 1'b0);
            chk("rst_pending", bus.pending, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("release_req_ready", bus.req_ready, 1'b1);
        bus.req_valid = 1'b0;

        for (int i = 0; i < 3000; i++) run_cycle(1'b1);

        // Mid-run reset: everything in flight is forgotten immediately.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.flush     = 1'b0;
        bus.wb_valid  = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_op_valid", bus.op_valid, 1'b0);
        chk("midrst_pending", bus.pending, 1'b0);
        chk("midrst_req_ready", bus.req_ready, 1'b0);
        exp_q.delete();
        for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
        @(negedge clk);
        reset         = 1'b1;
        bus.req_valid = 1'b0;

        for (int i = 0; i < 800; i++) run_cycle(1'b1);
        for (int i = 0; i < 4; i++) run_cycle(1'b0);
        chk("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch_unit.md
# operand_fetch_unit

Issue-side initiator for the two-read/one-write `Register_File`. It accepts decoded instructions over a valid/ready handshake and drives `Read_Reg1`/`Read_Reg2`. It bypasses same-cycle writeback data, tracks pending destination registers in a scoreboard, stalls on RAW/WAW hazards, and presents registered operands to the execute stage over a second valid/ready handshake.

## Interface
- `WORD_LENGTH`, 32, data width and register count
- `NBITS`, `CeilLog2(WORD_LENGTH)`, register address width
- `clk` in 1: the only clock; all state updates on the rising edge
- `reset` in 1: asynchronous, active-low; clears all state
- `req_valid` in 1: decoded instruction present
- `req_ready` out 1: instruction accepted this cycle when both are high
- `req_rs1`, `req_rs2` in NBITS: source register numbers
- `req_rd` in NBITS: destination register number
- `req_wen` in 1: instruction will write `req_rd`
- `rf_read_reg1`, `rf_read_reg2` out NBITS: register file read addresses
- `rf_read_data1`, `rf_read_data2` in WORD_LENGTH: register file read data
- `wb_valid` in 1: register file write occurs at the end of this cycle
- `wb_reg` in NBITS: register being written
- `wb_data` in WORD_LENGTH: data being written
- `flush` in 1: discard the held instruction
- `op_valid` out 1: operands valid
- `op_ready` in 1: execute stage consumes the operands
- `op_a`, `op_b` out WORD_LENGTH: operand values
- `op_rd` out NBITS: destination register of the held instruction
- `op_wen` out 1: write enable of the held instruction
- `pending` out 1: OR of all scoreboard bits

## Operation
- `rf_read_reg1 = req_rs1` and `rf_read_reg2 = req_rs2`, driven combinationally.
- Scoreboard: WORD_LENGTH bits. Bit r set means a write to r is in flight.
- Effective pending: `eff = sb & ~(wb_valid ? onehot(wb_reg) : 0)`.
- Hazard, when any of these holds:
  - `eff[req_rs1]`
  - `eff[req_rs2]`
  - `req_wen && eff[req_rd]` (WAW)
- Register 0 is an ordinary register. It is not hardwired to zero.
- `req_ready = reset && !flush && !hazard && (!op_valid || op_ready)`.
- On accept:
  - `op_a` = `wb_data` if `wb_valid && wb_reg == req_rs1`, else `rf_read_data1`. `op_b` follows the same rule with `req_rs2`.
  - Capture `op_rd` and `op_wen`.
  - Set `op_valid`.
- Scoreboard update each cycle: clear `wb_reg` if `wb_valid`, then set `req_rd` if accept && `req_wen`. When both target the same register, set wins.
- `wb_valid` for a non-pending register is legal and has no effect.
- When `op_valid && op_ready` and no new accept, clear `op_valid`. Data outputs hold their last value.
- Flush:
  - Next cycle: `op_valid` = 0.
  - If `op_valid && op_wen`, clear `sb[op_rd]`. This clear has priority over any set.
  - `req_ready` = 0 during the flush cycle.
  - Writebacks during flush are still applied.

## Timing
- Reset values:
  - `op_valid`, `op_wen`: 0
  - `op_a`, `op_b`: 0
  - `op_rd`: 0
  - scoreboard: 0, so `pending` = 0
  - `req_ready`: 0 while reset is asserted
- Latency: accept in cycle t gives `op_valid` in cycle t+1.
- Throughput: one instruction per cycle when there are no hazards and `op_ready` is held high.
- RAW: a consumer is accepted no earlier than the cycle its producer's `wb_valid` is high, with the operand taken from `wb_data`.
- Outputs are stable while `op_valid && !op_ready`.
- Reset asserted mid-operation: all state clears immediately. In-flight writebacks are forgotten.

## Structure
- Shared package holds:
  - `CeilLog2`
  - default `WORD_LENGTH`/`NBITS`
  - the onehot decode function, shared with `Register_File`'s write demux.
- Sub-module `reg_scoreboard`:
  - set port and clear port, with flush-clear priority
  - two lookup ports plus the WAW port
  - `pending` output

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `req_valid`=1 → `req_ready`=0, `op_valid`=0, `op_a`=0. Release → `req_ready`=1.
- Back-to-back: accept rs1=1/rs2=2 with rf data 0x11/0x22, then rs1=3/rs2=4 with 0x33/0x44 → `op_a`/`op_b` read 0x11/0x22 at t+1 and 0x33/0x44 at t+2. `req_ready` stays 1.
- RAW + bypass: accept rd=5 wen=1, then request rs1=5 → `req_ready`=0 until the cycle with `wb_valid`=1, `wb_reg`=5, `wb_data`=0xDEADBEEF. Accepted that cycle with `op_a`=0xDEADBEEF while `rf_read_data1`=0.
- WAW: rd=7 pending, request rd=7 wen=1, rs1=rs2=0 → stall until writeback of reg 7. Then accepted, and `sb[7]` remains set.
- Backpressure: `op_ready`=0 for 4 cycles → `op_a`/`op_b`/`op_rd` stable and `req_ready`=0. When `op_ready` returns to 1, the next request is accepted the same cycle.
- Flush: held instruction with rd=9 wen=1, assert `flush` → `op_valid`=0 next cycle and `sb[9]` cleared. A following request with rs1=9 is accepted without stall.
